// File: rtl/kbd_matrix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : kbd_matrix_pkg                                         |
// | Description : Shared types, constants and PS/2 scancode-to-matrix    |
// |               lookup for the PS/2 keyboard to key-matrix bridge.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package kbd_matrix_pkg;

  // Receiver FSM states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0]  c_PREFIX_RELEASE  = 8'hF0;
  localparam logic [7:0]  c_PREFIX_EXTENDED = 8'hE0;
  localparam logic [7:0]  c_CODE_F5         = 8'h03;
  localparam logic [7:0]  c_CODE_F12        = 8'h07;
  localparam int unsigned c_TIMEOUT         = 2048;
  localparam int unsigned c_FILTER          = 4;
  localparam int unsigned c_ROWS            = 8;
  localparam int unsigned c_COLS            = 5;

  // One matrix position; col is 0..4
  typedef struct packed {
    logic       valid;
    logic [2:0] row;
    logic [2:0] col;
  } key_pos_t;

  // A scancode may drive up to two matrix positions (e.g. Backspace)
  typedef struct packed {
    key_pos_t first;
    key_pos_t second;
  } key_pair_t;

  function automatic key_pos_t pos(input logic [2:0] r, input logic [2:0] c);
    return '{valid: 1'b1, row: r, col: c};
  endfunction

  // Scancode (with extended flag) to matrix position(s); unmapped -> none
  function automatic key_pair_t scan_lookup(input logic ext, input logic [7:0] sc);
    key_pair_t m;
    m = '0;
    case ({ext, sc})
      9'h012:         m.first = pos(3'd0, 3'd0);  // LShift -> Caps Shift
      9'h01A:         m.first = pos(3'd0, 3'd1);  // Z
      9'h01C:         m.first = pos(3'd1, 3'd0);  // A
      9'h015:         m.first = pos(3'd2, 3'd0);  // Q
      9'h016:         m.first = pos(3'd3, 3'd0);  // 1
      9'h045:         m.first = pos(3'd4, 3'd0);  // 0
      9'h04D:         m.first = pos(3'd5, 3'd0);  // P
      9'h05A:         m.first = pos(3'd6, 3'd0);  // Enter
      9'h029:         m.first = pos(3'd7, 3'd0);  // Space
      9'h014, 9'h114: m.first = pos(3'd7, 3'd1);  // L/R Ctrl -> Symbol Shift
      9'h066: begin                               // Backspace = Caps Shift + 0
        m.first  = pos(3'd0, 3'd0);
        m.second = pos(3'd4, 3'd0);
      end
      default:        m = '0;
    endcase
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/kbd_matrix_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : kbd_matrix_if                                          |
// | Description : Host-side bundle of the keyboard bridge: PS/2 lines,   |
// |               sample enable, row select and key/status outputs.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface kbd_matrix_if;
  logic       ce;
  logic       ps2Ck;
  logic       ps2D;
  logic [7:0] row;
  logic [4:0] col;
  logic       kNmi;
  logic       kReset;
  logic       strobe;
  logic [7:0] code;

  // Host / system side
  modport master (
    output ce, ps2Ck, ps2D, row,
    input  col, kNmi, kReset, strobe, code
  );

  // Keyboard bridge side
  modport slave (
    input  ce, ps2Ck, ps2D, row,
    output col, kNmi, kReset, strobe, code
  );
endinterface
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : ps2_rx                                                 |
// | Description : PS/2 byte receiver: synchronisers, clock glitch        |
// |               filter, frame FSM, odd-parity check and timeout.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module ps2_rx (
  input  wire logic       clock,
  input  wire logic       reset,
  input  wire logic       ce,
  input  wire logic       ps2Ck,
  input  wire logic       ps2D,
  output logic            strobe,
  output logic [7:0]      code
);
  import kbd_matrix_pkg::*;

  localparam logic [2:0]  c_FILT_LAST = 3'(c_FILTER - 1);
  localparam logic [11:0] c_TMO_LIMIT = 12'(c_TIMEOUT);

  logic [1:0]  r_ck_sync;
  logic [1:0]  r_d_sync;
  logic        r_ck_filt;
  logic [2:0]  r_filt_cnt;
  logic        w_fall;
  rx_state_t   r_state;
  rx_state_t   w_state_next;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_parity_ok;
  logic [11:0] r_tmo_cnt;
  logic        w_timeout;
  logic        w_start;
  logic        w_shift_en;
  logic        w_parity_en;
  logic        w_accept;

  // Two-flop synchronisers; idle PS/2 lines are high
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ck_sync <= 2'b11;
      r_d_sync  <= 2'b11;
    end else begin
      r_ck_sync <= {r_ck_sync[0], ps2Ck};
      r_d_sync  <= {r_d_sync[0], ps2D};
    end
  end

  // Accept a new PS/2 clock level only after c_FILTER agreeing ce samples
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ck_filt  <= 1'b1;
      r_filt_cnt <= '0;
    end else if (ce) begin
      if (r_ck_sync[1] == r_ck_filt) begin
        r_filt_cnt <= '0;
      end else if (r_filt_cnt == c_FILT_LAST) begin
        r_ck_filt  <= r_ck_sync[1];
        r_filt_cnt <= '0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 3'd1;
      end
    end
  end

  assign w_fall    = ce && r_ck_filt && !r_ck_sync[1] && (r_filt_cnt == c_FILT_LAST);
  assign w_timeout = (r_state != ST_IDLE) && (r_tmo_cnt == c_TMO_LIMIT);

  // Frame watchdog: ce ticks since the last falling edge while mid-frame
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tmo_cnt <= '0;
    end else if (r_state == ST_IDLE || w_fall) begin
      r_tmo_cnt <= '0;
    end else if (ce && !w_timeout) begin
      r_tmo_cnt <= r_tmo_cnt + 12'd1;
    end
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // FSM next-state: advance one field per accepted falling edge
  always_comb begin
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = ST_IDLE;
    end else if (w_fall) begin
      case (r_state)
        ST_IDLE:   if (!r_d_sync[1]) w_state_next = ST_DATA;
        ST_DATA:   if (r_bit_cnt == 3'd7) w_state_next = ST_PARITY;
        ST_PARITY: w_state_next = ST_STOP;
        ST_STOP:   w_state_next = ST_IDLE;
        default:   w_state_next = ST_IDLE;
      endcase
    end
  end

  // FSM outputs: datapath enables and the accept condition for the stop bit
  always_comb begin
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_parity_en = 1'b0;
    w_accept    = 1'b0;
    if (w_fall && !w_timeout) begin
      case (r_state)
        ST_IDLE:   w_start     = !r_d_sync[1];
        ST_DATA:   w_shift_en  = 1'b1;
        ST_PARITY: w_parity_en = 1'b1;
        ST_STOP:   w_accept    = r_d_sync[1] && r_parity_ok;
        default:   w_accept    = 1'b0;
      endcase
    end
  end

  // Data shift (LSB first), bit counter and odd-parity result
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_parity_ok <= 1'b0;
    end else begin
      if (w_start) r_bit_cnt <= '0;
      if (w_shift_en) begin
        r_shift   <= {r_d_sync[1], r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_parity_en) r_parity_ok <= ^{r_shift, r_d_sync[1]};
    end
  end

  // Publish a good byte with a single-cycle strobe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      strobe <= 1'b0;
      code   <= 8'h00;
    end else begin
      strobe <= w_accept;
      if (w_accept) code <= r_shift;
    end
  end

endmodule
`default_nettype wire

// File: rtl/kbd_matrix.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : kbd_matrix                                             |
// | Description : PS/2 keyboard to 8x5 key-matrix bridge: scancode       |
// |               decoder, key matrix, NMI/reset keys, column readout.  |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module kbd_matrix (
  input wire logic    clock,
  input wire logic    reset,
  kbd_matrix_if.slave bus
);
  import kbd_matrix_pkg::*;

  logic                              w_strobe;
  logic [7:0]                        w_code;
  logic                              r_release;
  logic                              r_extended;
  logic                              r_nmi;
  logic                              r_reset_key;
  logic [c_COLS-1:0][c_ROWS-1:0]     r_keys;   // [col][row], 1 = pressed
  key_pair_t                         w_map;
  logic [c_COLS-1:0]                 w_col;

  ps2_rx u_rx (
    .clock  (clock),
    .reset  (reset),
    .ce     (bus.ce),
    .ps2Ck  (bus.ps2Ck),
    .ps2D   (bus.ps2D),
    .strobe (w_strobe),
    .code   (w_code)
  );

  assign w_map = scan_lookup(r_extended, w_code);

  // Decode each received byte: prefixes arm flags, others press/release keys
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_release   <= 1'b0;
      r_extended  <= 1'b0;
      r_nmi       <= 1'b0;
      r_reset_key <= 1'b0;
      r_keys      <= '0;
    end else if (w_strobe) begin
      if (w_code == c_PREFIX_RELEASE) begin
        r_release <= 1'b1;
      end else if (w_code == c_PREFIX_EXTENDED) begin
        r_extended <= 1'b1;
      end else begin
        if (w_map.first.valid)  r_keys[w_map.first.col][w_map.first.row]   <= !r_release;
        if (w_map.second.valid) r_keys[w_map.second.col][w_map.second.row] <= !r_release;
        if (!r_extended && w_code == c_CODE_F5)  r_nmi       <= !r_release;
        if (!r_extended && w_code == c_CODE_F12) r_reset_key <= !r_release;
        r_release  <= 1'b0;
        r_extended <= 1'b0;
      end
    end
  end

  // Column n is pulled low when any selected (low) row has key n pressed
  for (genvar gc = 0; gc < c_COLS; gc++) begin : g_col
    assign w_col[gc] = ~|(~bus.row & r_keys[gc]);
  end

  assign bus.col    = w_col;
  assign bus.kNmi   = r_nmi;
  assign bus.kReset = r_reset_key;
  assign bus.strobe = w_strobe;
  assign bus.code   = w_code;

endmodule
`default_nettype wire

// File: tb/tb_kbd_matrix.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_kbd_matrix                                          |
// | Description : Self-checking bench for kbd_matrix with a key-level    |
// |               reference model, directed and random PS/2 frames.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_kbd_matrix;

  localparam int HALF  = 16;   // clocks per PS/2 half bit (8 ce ticks)
  localparam int N_MAP = 13;

  logic clock = 1'b0;
  logic reset = 1'b0;

  kbd_matrix_if bus ();

  kbd_matrix dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Sampling enable: one pulse every second clock
  initial begin
    bus.ce = 1'b0;
    forever begin
      @(negedge clock);
      bus.ce = 1'b1;
      @(negedge clock);
      bus.ce = 1'b0;
    end
  end

  int          n_total = 0;
  int          n_pass  = 0;
  int          n_fail  = 0;
  int          obs_strobes = 0;
  logic [7:0]  obs_code = 8'h00;

  // Count every strobe pulse seen and remember its byte
  always @(negedge clock) begin
    if (bus.strobe === 1'b1) begin
      obs_strobes++;
      obs_code = bus.code;
    end
  end

  // Reference key map: {extended, scancode} -> row, col (one line per position)
  logic [8:0] map_key [N_MAP] = '{9'h012, 9'h01A, 9'h01C, 9'h015, 9'h016, 9'h045,
                                  9'h04D, 9'h05A, 9'h029, 9'h014, 9'h114, 9'h066, 9'h066};
  int         map_row [N_MAP] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 7, 7, 0, 4};
  int         map_col [N_MAP] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0};
  logic [7:0] pool [12]       = '{8'h12, 8'h1A, 8'h1C, 8'h15, 8'h16, 8'h45,
                                  8'h4D, 8'h5A, 8'h29, 8'h14, 8'h66, 8'h03};

  // Model state
  bit         m_key [8][5];
  bit         m_rel, m_ext, m_nmi, m_rst;
  int         m_strobes = 0;
  logic [7:0] m_code = 8'h00;

  task automatic model_reset();
    foreach (m_key[r, c]) m_key[r][c] = 1'b0;
    m_rel = 0; m_ext = 0; m_nmi = 0; m_rst = 0;
  endtask

  task automatic model_byte(input logic [7:0] b, input bit good);
    if (good) begin
      m_strobes++;
      m_code = b;
      if (b == 8'hF0) m_rel = 1;
      else if (b == 8'hE0) m_ext = 1;
      else begin
        foreach (map_key[i])
          if (map_key[i] == {m_ext, b}) m_key[map_row[i]][map_col[i]] = !m_rel;
        if (!m_ext && b == 8'h03) m_nmi = !m_rel;
        if (!m_ext && b == 8'h07) m_rst = !m_rel;
        m_rel = 0;
        m_ext = 0;
      end
    end
  endtask

  function automatic logic [4:0] model_col(input logic [7:0] rw);
    logic [4:0] res;
    res = 5'h1F;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 8; r++)
        if (rw[r] == 1'b0 && m_key[r][c]) res[c] = 1'b0;
    return res;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ps2D = bits[i];
      repeat (HALF) @(negedge clock);
      bus.ps2Ck = 1'b0;
      repeat (HALF) @(negedge clock);
      bus.ps2Ck = 1'b1;
    end
    repeat (HALF) @(negedge clock);
    bus.ps2D = 1'b1;
  endtask

  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit bad);
    logic par;
    par = (~^b) ^ bad;   // odd parity over data + parity
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad);
    send_bits(frame_bits(b, bad), 11);
    model_byte(b, !bad);
    repeat (8) @(negedge clock);
  endtask

  task automatic check_state(input string tag, input logic [7:0] rw);
    bus.row = rw;
    @(negedge clock);
    check({tag, " col"},     32'(bus.col),    32'(model_col(rw)));
    check({tag, " strobes"}, 32'(obs_strobes), 32'(m_strobes));
    check({tag, " code"},    32'(obs_code),   32'(m_code));
    check({tag, " kNmi"},    32'(bus.kNmi),   32'(m_nmi));
    check({tag, " kReset"},  32'(bus.kReset), 32'(m_rst));
  endtask

  initial begin
    logic [7:0] b;
    int         sel;
    bit         bad;

    bus.ps2Ck = 1'b1;
    bus.ps2D  = 1'b1;
    bus.row   = 8'h00;
    model_reset();

    // Reset state
    repeat (4) @(negedge clock);
    check("reset col",    32'(bus.col),    32'h1F);
    check("reset kNmi",   32'(bus.kNmi),   32'h0);
    check("reset kReset", 32'(bus.kReset), 32'h0);
    check("reset strobe", 32'(bus.strobe), 32'h0);
    check("reset code",   32'(bus.code),   32'h00);
    reset = 1'b1;
    repeat (4) @(negedge clock);

    // Press A, read its half-row
    send_frame(8'h1C, 1'b0);
    check_state("pressA", 8'hFD);
    check("pressA col lit", 32'(bus.col), 32'h1E);

    // Typematic repeat of A
    send_frame(8'h1C, 1'b0);
    check_state("typematic", 8'hFD);

    // Release A
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    check_state("releaseA", 8'hFD);
    check("releaseA col lit", 32'(bus.col), 32'h1F);

    // Bad parity A discarded, then Q
    send_frame(8'h1C, 1'b1);
    check_state("badpar", 8'hFD);
    send_frame(8'h15, 1'b0);
    check_state("pressQ", 8'hFB);
    check("pressQ col lit", 32'(bus.col), 32'h1E);

    // Abandoned frame recovered by timeout, then Space
    send_bits(frame_bits(8'h29, 1'b0), 5);
    repeat (2 * 2048 + 200) @(negedge clock);
    send_frame(8'h29, 1'b0);
    check_state("timeout", 8'h7F);
    check("timeout code lit", 32'(obs_code), 32'h29);

    // Backspace and Z together
    send_frame(8'h66, 1'b0);
    send_frame(8'h1A, 1'b0);
    check_state("bksp all", 8'h00);
    check("bksp all lit", 32'(bus.col), 32'h1C);
    check_state("bksp row4", 8'hEF);

    // Right Ctrl via extended prefix
    send_frame(8'hE0, 1'b0);
    send_frame(8'h14, 1'b0);
    check_state("rctrl", 8'h7F);

    // Reset in the middle of an F5 frame
    send_bits(frame_bits(8'h03, 1'b0), 5);
    reset = 1'b0;
    model_reset();
    repeat (4) @(negedge clock);
    bus.row = 8'h00;
    @(negedge clock);
    check("midreset col",  32'(bus.col),  32'h1F);
    check("midreset kNmi", 32'(bus.kNmi), 32'h0);
    reset = 1'b1;
    repeat (4) @(negedge clock);
    send_frame(8'h03, 1'b0);
    check_state("F5 press", 8'h00);
    check("F5 press lit", 32'(bus.kNmi), 32'h1);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h03, 1'b0);
    check_state("F5 release", 8'h00);

    // Random byte stream against the model
    for (int it = 0; it < 40; it++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 2)       b = 8'hF0;
      else if (sel == 2) b = 8'hE0;
      else if (sel < 8)  b = pool[$urandom_range(0, 11)];
      else if (sel == 8) b = ($urandom_range(0, 1) == 0) ? 8'h03 : 8'h07;
      else               b = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      send_frame(b, bad);
      check_state($sformatf("rand%0d", it), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kbd_matrix.md
KBD_MATRIX -- requirements
Module: kbd_matrix

Interface
REQ-001 SHALL have port clock, input, 1: system clock; all state updates on posedge clock.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-003 SHALL have port ce, input, 1: sampling clock enable, 1-cycle pulse, rate 200 kHz to 8 MHz (e.g. pe7M0).
REQ-004 SHALL have port ps2Ck, input, 1: raw PS/2 clock line, asynchronous.
REQ-005 SHALL have port ps2D, input, 1: raw PS/2 data line, asynchronous.
REQ-006 SHALL have port row, input, 8: CPU address a[15:8]; active-low half-row select.
REQ-007 SHALL have port col, output, 5: active-low key columns read on port 0xFE bits 4:0.
REQ-008 SHALL have port kNmi, output, 1: high while F5 (0x03) is held.
REQ-009 SHALL have port kReset, output, 1: high while F12 (0x07) is held.
REQ-010 SHALL have port strobe, output, 1: 1-clock pulse when a valid byte is received.
REQ-011 SHALL have port code, output, 8: last valid byte, held until the next strobe.

Function
REQ-012 SHALL pass ps2Ck and ps2D through two-flop synchronisers clocked on every clock.
REQ-013 SHALL filter ps2Ck: the accepted level changes only after 4 consecutive ce samples agree; a falling edge is an accepted 1->0 change.
REQ-014 SHALL run a receiver FSM IDLE -> DATA -> PARITY -> STOP -> IDLE, sampling ps2D on each falling edge.
REQ-015 IDLE: a falling edge with ps2D=0 (start bit) goes to DATA; with ps2D=1 it stays in IDLE.
REQ-016 DATA: 8 bits, LSB first, tracked by a 3-bit counter; after bit 7 goes to PARITY.
REQ-017 PARITY: 8 data bits plus parity SHALL have odd parity; the result is latched and the FSM goes to STOP.
REQ-018 STOP: ps2D=1 with good parity yields strobe and code; otherwise the byte is discarded silently; returns to IDLE.
REQ-019 Timeout: a 12-bit ce counter, cleared on each falling edge, SHALL force IDLE at 2048 ce ticks outside IDLE; no strobe.
REQ-020 Decoder: byte 0xF0 sets the release flag; byte 0xE0 sets the extended flag; any other byte applies the flags and then clears both.
REQ-021 Non-prefix byte: a table lookup on {extended, code} gives up to two matrix positions (row 0-7, col 0-4); each is set (press) or cleared (release).
REQ-022 Mandatory map: LShift 12->r0c0; Z 1A->r0c1; A 1C->r1c0; Q 15->r2c0; 1 16->r3c0; 0 45->r4c0; P 4D->r5c0; Enter 5A->r6c0; Space 29->r7c0; LCtrl 14 and RCtrl E0 14->r7c1 (Symbol Shift); Backspace 66->r0c0 + r4c0.
REQ-023 Unmapped codes SHALL leave the matrix unchanged; F5 and F12 update only kNmi and kReset.
REQ-024 The matrix SHALL be a 40-bit register, 1=pressed; simultaneous press of any key set is allowed.
REQ-025 col[n] SHALL be combinational: 0 iff a row r exists with row[r]=0 and key[r][n]=1; row=0xFF gives col=5'h1F.
REQ-026 Latency: matrix and col SHALL update on the clock after the strobe.
REQ-027 A repeated make code for a held key (typematic) SHALL leave the matrix unchanged.

Reset
REQ-028 On reset: FSM=IDLE, counters=0, flags=0, matrix=0, filtered clock=1, strobe=0, code=0x00, kNmi=0, kReset=0, col=5'h1F.
REQ-029 Reset asserted mid-frame SHALL discard the partial byte; the first complete frame after release SHALL decode normally.

Structure
REQ-030 The shared package SHALL hold the FSM state enum, the prefix constants (F0, E0), TIMEOUT=2048, FILTER=4, and the scancode-to-position table as a constant function.
REQ-031 The receiver (sync, filter, FSM, parity, timeout) SHALL be one sub-module, ps2_rx; the decoder, matrix and column logic SHALL stay in kbd_matrix.

Verification
REQ-032 Frame 0x1C with good parity, then row=8'hFD -> strobe once, code=0x1C, col=5'h1E.
REQ-033 Frames F0,1C after REQ-032 -> col=5'h1F for row=8'hFD; kNmi=0 and kReset=0 throughout.
REQ-034 Frame 0x1C with bad parity -> no strobe, col stays 5'h1F; a following good frame 0x15 with row=8'hFB -> col=5'h1E.
REQ-035 Stop after 4 data bits for 2048 ce ticks, then full frame 0x29 -> single strobe with code=0x29; row=8'h7F -> col=5'h1E.
REQ-036 Press 0x66 and 0x1A, row=8'h00 -> col=5'h1C; row=8'hEF -> col=5'h1E.
REQ-037 Assert reset after 5 bits of frame 0x03 -> col=5'h1F, kNmi=0; after release, frame 0x03 -> kNmi=1; frames F0,03 -> kNmi=0.
